// File: rtl/ram_access_ctrl.sv
// Control stage for the lab's 32x4 dual-port RAM. It turns a debounced-free push-button into a
// single registered write strobe and runs a read scanner that feeds the display outputs.
module ram_access_ctrl #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 4,
  parameter int SCAN_TICKS  = 50000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              wr_key_n,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [DATA_W-1:0] wr_data_in,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_rdaddress,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid
);

  localparam int CNT_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(SCAN_TICKS - 1);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_ISSUE = 2'd1,
    S_LATCH = 2'd2
  } scan_state_e;

  logic [SYNC_STAGES-1:0] r_key_sync;
  logic                   r_key_prev;
  logic                   r_press;
  logic                   w_key_cur;
  logic                   w_press_det;

  logic [CNT_W-1:0]       r_tick;
  logic                   w_tick_wrap;
  scan_state_e            r_state;
  scan_state_e            w_next_state;
  logic                   r_issue_byp;
  logic                   w_wr_hits_disp;
  logic                   w_wr_hits_rd;

  // ---------------------------------------------------------------------------
  // Key synchroniser and press detection. Everything resets to the pressed
  // level so a key held through reset release never looks like a fresh press.
  // ---------------------------------------------------------------------------
  assign w_key_cur   = r_key_sync[SYNC_STAGES-1];
  assign w_press_det = r_key_prev & ~w_key_cur;

  // NOTE: sequential state uses <= so every flop samples its pre-edge input;
  // with = the synchroniser chain would collapse into a single stage.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_key_sync <= '0;
      r_key_prev <= 1'b0;
      r_press    <= 1'b0;
    end else begin
      r_key_sync <= {r_key_sync[SYNC_STAGES-2:0], wr_key_n};
      r_key_prev <= w_key_cur;
      r_press    <= w_press_det;
    end
  end

  // Write port: one-cycle strobe after the registered detect; address and
  // data are captured with it and held until the next press.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      ram_wren      <= 1'b0;
      ram_wraddress <= '0;
      ram_data      <= '0;
    end else begin
      ram_wren <= r_press;
      if (r_press) begin
        ram_wraddress <= wr_addr_in;
        ram_data      <= wr_data_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scan timing: the tick counter never stops, so the scan period is exactly
  // SCAN_TICKS cycles regardless of the ISSUE/LATCH detour.
  // ---------------------------------------------------------------------------
  assign w_tick_wrap = (r_tick == TICK_LAST);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_tick <= '0;
    end else if (w_tick_wrap) begin
      r_tick <= '0;
    end else begin
      r_tick <= r_tick + CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_ISSUE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: w_next_state gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_WAIT:  if (w_tick_wrap) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_LATCH;
      S_LATCH: w_next_state = S_WAIT;
      default: w_next_state = S_WAIT;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      ram_rdaddress <= '0;
    end else if (r_state == S_WAIT && w_tick_wrap) begin
      ram_rdaddress <= ram_rdaddress + ADDR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Display and write coherence. The RAM returns old data when a read and a
  // write to the same word share an edge, so such writes are forwarded here.
  // A write during ISSUE is remembered for the LATCH that follows it.
  // ---------------------------------------------------------------------------
  assign w_wr_hits_disp = ram_wren && (ram_wraddress == disp_addr);
  assign w_wr_hits_rd   = ram_wren && (ram_wraddress == ram_rdaddress);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_issue_byp <= 1'b0;
    end else begin
      r_issue_byp <= (r_state == S_ISSUE) && w_wr_hits_rd;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      disp_addr  <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
    end else begin
      disp_valid <= 1'b0;
      if (r_state == S_LATCH) begin
        disp_valid <= 1'b1;
        disp_addr  <= ram_rdaddress;
        disp_data  <= (w_wr_hits_rd || r_issue_byp) ? ram_data : ram_q;
      end else if (w_wr_hits_disp) begin
        disp_data <= ram_data;
      end
    end
  end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
Control stage between the board inputs and the 32x4 dual-port RAM used in the lab. It turns a raw, asynchronous push-button into a single-cycle, registered write strobe carrying registered address and data. It also runs a free-running read scanner that steps through every RAM word at a fixed rate and presents the address and data on display outputs. It drives the RAM write and read ports and consumes the RAM read data.

Parameters:
ADDR_W, 5, RAM address width (32 words)
DATA_W, 4, RAM word width
SCAN_TICKS, 50000000, clock cycles per scan step (1 s at 50 MHz); minimum 4
SYNC_STAGES, 2, synchroniser depth on the key input; minimum 2

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous, active-low reset
wr_key_n  in  1  raw active-low write button, asynchronous to CLOCK_50
wr_addr_in  in  ADDR_W  write address from switches
wr_data_in  in  DATA_W  write data from switches
ram_wraddress  out  ADDR_W  RAM write address, registered
ram_data  out  DATA_W  RAM write data, registered
ram_wren  out  1  RAM write enable, one-cycle pulse
ram_rdaddress  out  ADDR_W  RAM read address, registered
ram_q  in  DATA_W  RAM read data, valid one cycle after ram_rdaddress is sampled
disp_addr  out  ADDR_W  address currently displayed
disp_data  out  DATA_W  data currently displayed
disp_valid  out  1  one-cycle pulse when disp_addr/disp_data update from a scan

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All outputs are 0; ram_wren is forced to 0 immediately.
  - Synchroniser chain and edge register reset to 0 (the "pressed" level), so a key held through reset produces no write.
  - Tick counter is 0.
  - Scan FSM resets to ISSUE with ram_rdaddress = 0, so word 0 is displayed first.
- Write path:
  - wr_key_n passes through SYNC_STAGES flops; a registered copy of the synchronised value gives the previous level.
  - A press is previous = 1 and current = 0.
  - On the cycle after a press is detected, ram_wren = 1 for exactly one cycle. In that cycle ram_wraddress and ram_data hold wr_addr_in and wr_data_in, sampled on the detect cycle.
  - Holding the key gives no repeat writes. A release followed by a new press gives a new write.
  - Press-to-wren latency is SYNC_STAGES + 2 cycles from the first edge on which the low level is sampled.
  - ram_wraddress and ram_data keep their values between writes.
- Scan FSM (states WAIT, ISSUE, LATCH):
  - WAIT: tick counter runs 0..SCAN_TICKS-1. On SCAN_TICKS-1 the counter goes to 0, ram_rdaddress increments (31 wraps to 0), and the FSM goes to ISSUE.
  - ISSUE: one cycle; the RAM samples ram_rdaddress. Next state is LATCH.
  - LATCH: one cycle. disp_data <= ram_q, disp_addr <= ram_rdaddress, disp_valid = 1 for this one cycle. Next state is WAIT.
  - The tick counter keeps running through ISSUE and LATCH, so the scan period is exactly SCAN_TICKS cycles.
- Write/display coherence (bypass):
  - If ram_wren = 1 and ram_wraddress equals disp_addr, disp_data <= ram_data on the next edge.
  - If that write coincides with a LATCH capture of the same address, the bypass wins, because the RAM returns old data.
  - The bypass does not pulse disp_valid.
- Writes and scans are independent; a write never stalls the scanner.
- Widths: all address arithmetic is modulo 2^ADDR_W; there are no overflow flags.

Test Plan:
- Reset and first display: SCAN_TICKS = 4, release reset_n; the RAM model holds word0 = 4'hA -> 2 cycles after release disp_addr = 0, disp_data = A, and disp_valid pulses once.
- Single write: wr_addr_in = 5, wr_data_in = 4'h9, hold wr_key_n low for 20 cycles -> exactly one ram_wren pulse, at SYNC_STAGES + 2 cycles, with ram_wraddress = 5 and ram_data = 9.
- Scan and wrap: SCAN_TICKS = 4, run 140 cycles -> disp_valid every 4 cycles; disp_addr steps 0, 1, …, 31, 0; disp_data matches the RAM model each time.
- Write bypass: while disp_addr = 7, write 4'h3 to address 7 -> disp_data = 3 on the cycle after ram_wren, with no disp_valid; write to address 8 -> disp_data unchanged.
- Collision: time a write to address N so ram_wren coincides with LATCH for N (old data 4'h1, new 4'hE) -> disp_data = E.
- Reset mid-operation: assert reset_n during ram_wren and during LATCH -> ram_wren drops immediately and all outputs are 0. Holding wr_key_n low through reset release -> no write.
